// File: rtl/inv_share_ctrl.sv
// Two-port sequencer that time-shares one inverter bank, waits a settle interval, and returns a tagged result.
// Optional feature macro INV_NEG_EN adds r0_neg and a post-capture incrementer for two's complement on port 0.
module inv_share_ctrl #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    input  logic [WIDTH-1:0] r0_data,
`ifdef INV_NEG_EN
    input  logic             r0_neg,
`endif
    output logic             r0_ready,
    input  logic             r1_valid,
    input  logic [WIDTH-1:0] r1_data,
    output logic             r1_ready,
    output logic [WIDTH-1:0] inv_in,
    input  logic [WIDTH-1:0] inv_out,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] cnt_r;
    logic       id_r;
    logic       last_grant_r;
    logic       grant0_s;
    logic       grant1_s;
    logic       accept0_s;
    logic       accept1_s;
`ifdef INV_NEG_EN
    logic       neg_r;
`endif

    // Round-robin grant: contention goes to the port that was not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (r0_valid && (!r1_valid || last_grant_r)) begin
            grant0_s = 1'b1;
        end else if (r1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign r0_ready  = (state_r == IDLE) && grant0_s;
    assign r1_ready  = (state_r == IDLE) && grant1_s;
    assign accept0_s = r0_ready && r0_valid;
    assign accept1_s = r1_ready && r1_valid;
    assign busy      = (state_r != IDLE);

    // Next-state logic for the accept / settle / respond sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept0_s || accept1_s) next_state_s = SETTLE;
                else                        next_state_s = IDLE;
            end
            SETTLE: begin
                if (cnt_r == CNT_LAST) next_state_s = RESP;
                else                   next_state_s = SETTLE;
            end
            RESP: begin
                if (res_ready) next_state_s = IDLE;
                else           next_state_s = RESP;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    // Operand latch, settle counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_in       <= {WIDTH{1'b0}};
            id_r         <= 1'b0;
            last_grant_r <= 1'b1;
            cnt_r        <= 4'd0;
            res_valid    <= 1'b0;
            res_data     <= {WIDTH{1'b0}};
            res_id       <= 1'b0;
`ifdef INV_NEG_EN
            neg_r        <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= 4'd0;
                    if (accept0_s) begin
                        inv_in       <= r0_data;
                        id_r         <= 1'b0;
                        last_grant_r <= 1'b0;
`ifdef INV_NEG_EN
                        neg_r        <= r0_neg;
`endif
                    end else if (accept1_s) begin
                        inv_in       <= r1_data;
                        id_r         <= 1'b1;
                        last_grant_r <= 1'b1;
`ifdef INV_NEG_EN
                        neg_r        <= 1'b0;
`endif
                    end
                end
                SETTLE: begin
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == CNT_LAST) begin
`ifdef INV_NEG_EN
                        res_data <= inv_out + {{(WIDTH-1){1'b0}}, neg_r};
`else
                        res_data <= inv_out;
`endif
                        res_id    <= id_r;
                        res_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: begin
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/inv_share_ctrl.md
# inv_share_ctrl

Sequencer/arbiter sharing one 32-bit gate-level inverter bank between two ALU requesters: port 0 (subtract path, operand-B complement) and port 1 (NOT/NOR result path). It accepts one operand at a time and drives it onto the bank. It waits a fixed settle interval, because the bank has real gate delay, then captures the bank output into a result register. It returns the result with a requester tag over a valid/ready interface.

## Interface
- WIDTH, 32: operand/result width.
- SETTLE_CYCLES, 2: clock cycles `inv_in` is held before capture; legal range 1..15.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- r0_valid  in  1  port 0 request.
- r0_data  in  WIDTH  port 0 operand.
- r0_neg  in  1  port 0 two's-complement request (only with INV_NEG_EN).
- r0_ready  out  1  port 0 accept.
- r1_valid  in  1  port 1 request.
- r1_data  in  WIDTH  port 1 operand.
- r1_ready  out  1  port 1 accept.
- inv_in  out  WIDTH  registered operand to the inverter bank.
- inv_out  in  WIDTH  inverter bank output.
- res_valid  out  1  result available.
- res_data  out  WIDTH  captured result.
- res_id  out  1  originating port (0/1).
- res_ready  in  1  result consumer accept.
- busy  out  1  state != IDLE.

One clock, `clk`. Reset `rst_n` is asynchronous and active-low.

## Operation
- States:
  - IDLE: no operation in flight.
  - SETTLE: counter `cnt` runs 0..SETTLE_CYCLES-1.
  - RESP: result held.
- Arbitration, evaluated combinationally in IDLE only:
  - With a single valid port, that port is granted.
  - With both valid, the port not in `last_grant` is granted (round-robin).
  - `rN_ready` = IDLE and grant_N. At most one ready is high at a time.
  - Both readies are 0 outside IDLE.
- Accept (IDLE, valid & ready at edge):
  - Latch `inv_in` <= data, `id` <= N, `last_grant` <= N.
  - Latch `neg` <= r0_neg & (N==0).
  - `cnt` <= 0, go to SETTLE.
- SETTLE: `cnt` increments each edge. On the edge where `cnt` == SETTLE_CYCLES-1:
  - `res_data` <= inv_out (+1 if `neg`).
  - `res_id` <= id, `res_valid` <= 1.
  - Go to RESP.
- RESP:
  - `res_valid` high and `res_data`/`res_id` stable until res_valid & res_ready at an edge.
  - At that edge: `res_valid` <= 0, go to IDLE.
  - No new accept on that same edge. The next accept is earliest the following edge.
- `inv_in` holds its last operand after capture. It changes only on accept or reset.
- Requester data/valid changes while not ready are ignored.
- Width/arithmetic:
  - Negation is WIDTH-bit with the carry discarded (wrap).
  - 0 -> 0.
  - 0x8000_0000 -> 0x8000_0000.

## Timing
- Reset (async assert, synchronous-to-clk release):
  - state = IDLE, `inv_in` = 0, `res_valid` = 0, `res_data` = 0, `res_id` = 0, busy = 0.
  - `last_grant` = 1, so port 0 wins the first simultaneous request.
  - r0_ready/r1_ready follow the arbitration from the valids immediately after reset.
- Latency: accept at edge k; capture at edge k+SETTLE_CYCLES; `res_valid` high from then.
  - Minimum throughput is one operation per SETTLE_CYCLES+2 cycles: accept, settle, one RESP cycle, return to IDLE.
- `res_ready` held high: RESP lasts exactly one cycle.
- Reset mid-SETTLE or mid-RESP: operation discarded, outputs return to reset values, no result emitted.
- SETTLE_CYCLES × clock period must exceed worst-case bank delay (10 time units per gate). Meeting this is the integrator's responsibility.

## Configuration
- INV_NEG_EN defined:
  - `r0_neg` port present.
  - A WIDTH-bit incrementer follows capture and two's complement is available to port 0.
- Undefined:
  - `r0_neg` port absent.
  - `neg` register and incrementer removed.
  - `res_data` is always the raw `inv_out`.

## Test plan
- Reset, then r0_valid with r0_data=0x0000_00FF, SETTLE_CYCLES=2, res_ready=1:
  - r0_ready=1 at accept.
  - res_valid=1 two edges later, res_data=0xFFFF_FF00, res_id=0.
  - busy low again after the RESP cycle.
- Both valid every cycle (r0=0x1, r1=0x2), res_ready=1:
  - Grants alternate 0,1,0,1.
  - First result is 0xFFFF_FFFE id 0, second is 0xFFFF_FFFD id 1.
- res_ready=0 for 5 cycles after capture:
  - res_valid, res_data and res_id stay stable.
  - r0_ready/r1_ready stay 0.
  - Result accepted on the first edge with res_ready=1.
- INV_NEG_EN, r0_neg=1:
  - 0x0000_0005 -> 0xFFFF_FFFB.
  - 0x0 -> 0x0.
  - 0x8000_0000 -> 0x8000_0000.
  - r1 request with r0_neg=1 is unaffected (plain inversion).
- rst_n pulsed low during SETTLE (cnt=0):
  - Outputs return to reset values asynchronously.
  - No res_valid follows.
  - Next simultaneous request is granted to port 0.
- SETTLE_CYCLES=1 and 15: capture occurs exactly 1 and 15 edges after accept.
